// File: rtl/la_ram_dump.sv
// la_ram_dump: streams a range of CPU RAM words to the management core over
// the logic analyzer bus, one word per toggle handshake, holding the CPU off
// the RAM port for the duration of the dump.
module la_ram_dump #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              la_start,
  input  logic              la_abort,
  input  logic              la_ack_tgl,
  input  logic [ADDR_W-1:0] la_start_addr,
  input  logic [ADDR_W-1:0] la_count,
  output logic [DATA_W-1:0] la_data,
  output logic [ADDR_W-1:0] la_addr,
  output logic              la_valid_tgl,
  output logic              busy,
  output logic              done,
  output logic              cpu_hold,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata
);

  // Remaining-word counter needs one extra bit so a full-depth dump fits.
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_READ,
    S_CAPTURE,
    S_PRESENT
  } state_t;

  state_t state, state_n;

  logic [1:0]        start_sync, abort_sync, ack_sync;
  logic              start_s, abort_s, ack_s;
  logic              start_d;
  logic              ack_ref;
  logic              start_rise;
  logic [ADDR_W-1:0] ptr;
  logic [CNT_W-1:0]  remaining;

  logic              load;
  logic              capture;
  logic              ack_hit;
  logic              finish;

  assign start_s    = start_sync[1];
  assign abort_s    = abort_sync[1];
  assign ack_s      = ack_sync[1];
  assign start_rise = start_s & ~start_d;

  // Decodes of the state register; these fall with the state on reset.
  assign busy      = (state != S_IDLE);
  assign cpu_hold  = busy;
  assign ram_rd_en = (state == S_READ);
  assign ram_addr  = ptr;

  // Two-flop synchronisers for the LA control inputs.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      start_sync <= 2'b00;
      abort_sync <= 2'b00;
      ack_sync   <= 2'b00;
    end else begin
      start_sync <= {start_sync[0], la_start};
      abort_sync <= {abort_sync[0], la_abort};
      ack_sync   <= {ack_sync[0], la_ack_tgl};
    end
  end

  // State register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and datapath control; abort overrides everything once busy.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    capture = 1'b0;
    ack_hit = 1'b0;
    finish  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_rise && !abort_s) begin
          state_n = S_HOLD;
          load    = 1'b1;
        end
      end
      S_HOLD: begin
        state_n = abort_s ? S_IDLE : S_READ;
      end
      S_READ: begin
        state_n = abort_s ? S_IDLE : S_CAPTURE;
      end
      S_CAPTURE: begin
        if (abort_s) begin
          state_n = S_IDLE;
        end else begin
          state_n = S_PRESENT;
          capture = 1'b1;
        end
      end
      S_PRESENT: begin
        if (abort_s) begin
          state_n = S_IDLE;
        end else if (ack_s != ack_ref) begin
          ack_hit = 1'b1;
          if (remaining == '0) begin
            state_n = S_IDLE;
            finish  = 1'b1;
          end else begin
            state_n = S_READ;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Pointer, word counter, presented word and handshake bookkeeping.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      start_d      <= 1'b0;
      ack_ref      <= 1'b0;
      ptr          <= '0;
      remaining    <= '0;
      la_data      <= '0;
      la_addr      <= '0;
      la_valid_tgl <= 1'b0;
      done         <= 1'b0;
    end else begin
      start_d <= start_s;
      // Acks arriving outside PRESENT are absorbed so they never skip a word.
      if (state != S_PRESENT || ack_hit) begin
        ack_ref <= ack_s;
      end
      if (load) begin
        ptr       <= la_start_addr;
        remaining <= (la_count == '0) ? {1'b1, {ADDR_W{1'b0}}}
                                      : {1'b0, la_count};
        done      <= 1'b0;
      end
      if (capture) begin
        la_data      <= ram_rdata;
        la_addr      <= ptr;
        la_valid_tgl <= ~la_valid_tgl;
        ptr          <= ptr + ADDR_W'(1);
        remaining    <= remaining - CNT_W'(1);
      end
      if (finish) begin
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_la_ram_dump.sv
// Bench for la_ram_dump: a RAM model, a word-level scoreboard of the dump
// that firmware should observe, and directed firmware-style sequences.
`timescale 1ns/1ps
module tb_la_ram_dump;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } word_t;

  logic              clk;
  logic              wb_rst_i;
  logic              la_start;
  logic              la_abort;
  logic              la_ack_tgl;
  logic [ADDR_W-1:0] la_start_addr;
  logic [ADDR_W-1:0] la_count;
  logic [DATA_W-1:0] la_data;
  logic [ADDR_W-1:0] la_addr;
  logic              la_valid_tgl;
  logic              busy;
  logic              done;
  logic              cpu_hold;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  logic [DATA_W-1:0] mem [DEPTH];
  word_t             exp_q [$];
  word_t             last;
  logic              prev_tgl;
  int                checks;
  int                errors;
  int                words_seen;
  int                rd_pulses;

  la_ram_dump #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (wb_rst_i),
    .la_start      (la_start),
    .la_abort      (la_abort),
    .la_ack_tgl    (la_ack_tgl),
    .la_start_addr (la_start_addr),
    .la_count      (la_count),
    .la_data       (la_data),
    .la_addr       (la_addr),
    .la_valid_tgl  (la_valid_tgl),
    .busy          (busy),
    .done          (done),
    .cpu_hold      (cpu_hold),
    .ram_rd_en     (ram_rd_en),
    .ram_addr      (ram_addr),
    .ram_rdata     (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (ram_rd_en) ram_rdata <= mem[ram_addr];
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Compare process: every cycle, checks reads and presented words against the scoreboard.
  always @(posedge clk) begin
    #1;
    if (wb_rst_i) begin
      prev_tgl = 1'b0;
      last.a   = '0;
      last.d   = '0;
    end else begin
      chk("hold_eq_busy", cpu_hold, busy);
      if (ram_rd_en) begin
        rd_pulses++;
        if (exp_q.size() > 0) chk("ram_addr", ram_addr, exp_q[0].a);
        else chk("rd_unexpected", ram_rd_en, 1'b0);
      end
      if (la_valid_tgl !== prev_tgl) begin
        words_seen++;
        if (exp_q.size() > 0) begin
          last = exp_q.pop_front();
          chk("word_addr", la_addr, last.a);
          chk("word_data", la_data, last.d);
          chk("busy_on_word", busy, 1'b1);
        end else begin
          chk("tgl_unexpected", la_valid_tgl, prev_tgl);
        end
        prev_tgl = la_valid_tgl;
      end else begin
        chk("data_stable", la_data, last.d);
        chk("addr_stable", la_addr, last.a);
      end
    end
  end

  // Queue the words a dump must deliver, then raise a start edge.
  task automatic start_dump(input int sa, input int cnt);
    int n;
    n = (cnt == 0) ? DEPTH : cnt;
    for (int i = 0; i < n; i++) begin
      word_t w;
      w.a = ADDR_W'((sa + i) % DEPTH);
      w.d = DATA_W'(8'hA0 + ((sa + i) % DEPTH));
      exp_q.push_back(w);
    end
    la_start_addr = ADDR_W'(sa);
    la_count      = ADDR_W'(cnt);
    la_start      = 1'b1;
    repeat (4) @(negedge clk);
    la_start      = 1'b0;
  endtask

  task automatic wait_words(input int target, input string name);
    int n = 0;
    while (words_seen < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, words_seen, target);
  endtask

  task automatic ack();
    la_ack_tgl = ~la_ack_tgl;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(name, busy, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_la_data"}, la_data, '0);
    chk({tag, "_la_addr"}, la_addr, '0);
    chk({tag, "_tgl"}, la_valid_tgl, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_cpu_hold"}, cpu_hold, 1'b0);
    chk({tag, "_rd_en"}, ram_rd_en, 1'b0);
    chk({tag, "_ram_addr"}, ram_addr, '0);
  endtask

  initial begin
    int wb, rb, n;
    checks = 0; errors = 0; words_seen = 0; rd_pulses = 0;
    prev_tgl = 1'b0; last.a = '0; last.d = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(8'hA0 + i);
    ram_rdata = '0;
    wb_rst_i = 1'b1; la_start = 1'b0; la_abort = 1'b0; la_ack_tgl = 1'b0;
    la_start_addr = '0; la_count = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    wb_rst_i = 1'b0;
    repeat (3) @(negedge clk);

    // Basic three-word dump from address 0.
    wb = words_seen; rb = rd_pulses;
    start_dump(0, 3);
    for (int i = 1; i <= 3; i++) begin
      wait_words(wb + i, "basic_word");
      ack();
    end
    wait_idle("basic_idle");
    chk("basic_done", done, 1'b1);
    chk("basic_rd_count", rd_pulses - rb, 3);
    chk("basic_last_data", la_data, 8'hA2);
    chk("basic_last_addr", la_addr, 4'd2);

    // Stale ack while idle, then a wrapping dump 14,15,0,1.
    ack();
    repeat (5) @(negedge clk);
    wb = words_seen; rb = rd_pulses;
    start_dump(14, 4);
    wait_words(wb + 1, "wrap_word");
    repeat (8) @(negedge clk);
    chk("wrap_stale_ack_rd", rd_pulses - rb, 1);
    ack();
    for (int i = 2; i <= 4; i++) begin
      wait_words(wb + i, "wrap_word");
      ack();
    end
    wait_idle("wrap_idle");
    chk("wrap_done", done, 1'b1);
    chk("wrap_last_addr", la_addr, 4'd1);
    chk("wrap_last_data", la_data, 8'hA1);

    // Count of zero dumps the full RAM; done only after the last ack.
    wb = words_seen; rb = rd_pulses;
    start_dump(0, 0);
    for (int i = 1; i <= 15; i++) begin
      wait_words(wb + i, "full_word");
      ack();
    end
    wait_words(wb + 16, "full_word16");
    repeat (5) @(negedge clk);
    chk("full_done_before_ack", done, 1'b0);
    chk("full_busy_before_ack", busy, 1'b1);
    ack();
    wait_idle("full_idle");
    chk("full_done", done, 1'b1);
    chk("full_rd_count", rd_pulses - rb, 16);
    chk("full_last_data", la_data, 8'hAF);

    // Abort after the second word is presented.
    wb = words_seen; rb = rd_pulses;
    start_dump(0, 5);
    wait_words(wb + 1, "abort_word");
    ack();
    wait_words(wb + 2, "abort_word");
    la_abort = 1'b1;
    n = 0;
    while (busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("abort_latency_ok", (n <= 3) ? 1 : 0, 1);
    chk("abort_cpu_hold", cpu_hold, 1'b0);
    repeat (10) @(negedge clk);
    chk("abort_done", done, 1'b0);
    chk("abort_rd_count", rd_pulses - rb, 2);
    chk("abort_words", words_seen - wb, 2);
    chk("abort_data", la_data, 8'hA1);
    exp_q.delete();
    // Held abort blocks a start.
    la_start = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_blocks_start", busy, 1'b0);
    la_start = 1'b0;
    repeat (4) @(negedge clk);
    la_abort = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_release_idle", busy, 1'b0);

    // Backpressure with a start edge issued while busy.
    wb = words_seen; rb = rd_pulses;
    start_dump(0, 3);
    wait_words(wb + 1, "bp_word");
    la_start = 1'b1;
    repeat (50) @(negedge clk);
    la_start = 1'b0;
    chk("bp_rd_count", rd_pulses - rb, 1);
    chk("bp_data", la_data, 8'hA0);
    chk("bp_busy", busy, 1'b1);
    ack();
    wait_words(wb + 2, "bp_word");
    ack();
    wait_words(wb + 3, "bp_word");
    ack();
    wait_idle("bp_idle");
    repeat (20) @(negedge clk);
    chk("bp_no_requeue", busy, 1'b0);
    chk("bp_words", words_seen - wb, 3);
    chk("bp_done", done, 1'b1);

    // Reset during READ, then a clean dump.
    start_dump(3, 4);
    n = 0;
    while (!ram_rd_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reached_read", ram_rd_en, 1'b1);
    wb_rst_i = 1'b1;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    repeat (2) @(negedge clk);
    wb_rst_i = 1'b0;
    repeat (3) @(negedge clk);
    wb = words_seen; rb = rd_pulses;
    start_dump(5, 2);
    wait_words(wb + 1, "post_rst_word");
    ack();
    wait_words(wb + 2, "post_rst_word");
    ack();
    wait_idle("post_rst_idle");
    chk("post_rst_done", done, 1'b1);
    chk("post_rst_rd_count", rd_pulses - rb, 2);
    chk("post_rst_addr", la_addr, 4'd6);
    chk("post_rst_data", la_data, 8'hA6);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/la_ram_dump.md
Name: la_ram_dump

Overview:
- User-project block that reads the simple CPU's RAM back to the management core over the logic analyzer (LA) bus.
- It is the readback counterpart of the LA RAM-load path: firmware requests a range, and the block streams one word at a time onto LA inputs.
- Transfers use a toggle handshake so slow firmware polling can pace the transfer.
- While a dump runs, the block holds the CPU off the RAM port.

Parameters:
ADDR_W, 4, RAM address width; the RAM depth is 2**ADDR_W words.
DATA_W, 8, RAM word width.

Ports:
wb_clk_i  in  1  single clock shared with the CPU and RAM
wb_rst_i  in  1  asynchronous, active-high reset
la_start  in  1  start request from LA, a level; a rising edge starts a dump
la_abort  in  1  abort from LA, a level; high forces the block to IDLE
la_ack_tgl  in  1  firmware toggles this after consuming a word
la_start_addr  in  ADDR_W  first RAM address
la_count  in  ADDR_W  number of words; 0 means 2**ADDR_W
la_data  out  DATA_W  current word
la_addr  out  ADDR_W  address of current word
la_valid_tgl  out  1  toggles once when each new word is on la_data/la_addr
busy  out  1  high whenever the state is not IDLE
done  out  1  sticky, set at end of dump, cleared by next accepted start
cpu_hold  out  1  request for the CPU to release the RAM port; equals busy
ram_rd_en  out  1  one-cycle RAM read strobe
ram_addr  out  ADDR_W  RAM read address
ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_rd_en

Behaviour:
- Input synchronisation: la_start, la_abort and la_ack_tgl each pass through 2-FF synchronisers, adding 2 cycles of latency. Edge and toggle detection use the synchronised value against a registered copy.
- Reset values: all outputs 0; state IDLE; the internal ack reference equals the synchronised la_ack_tgl.
- States: IDLE, HOLD, READ, CAPTURE, PRESENT.
- IDLE -> HOLD on a synchronised la_start rising edge, only when abort is low.
  - Latch start_addr into the address pointer.
  - Latch the count into remaining; a count of 0 loads 2**ADDR_W using an ADDR_W+1-bit counter.
  - Clear done and assert busy and cpu_hold.
- HOLD: waits exactly 1 cycle so the CPU sees cpu_hold before the first read, then -> READ.
- READ:
  - ram_rd_en=1 for exactly 1 cycle, with ram_addr = pointer.
  - -> CAPTURE.
- CAPTURE:
  - la_data <= ram_rdata; la_addr <= pointer.
  - Flip la_valid_tgl.
  - pointer <= pointer+1, wrapping mod 2**ADDR_W.
  - remaining <= remaining-1.
  - -> PRESENT.
- PRESENT: wait for the synchronised la_ack_tgl to differ from the ack reference. On that cycle, update the reference.
  - If remaining==0: set done, -> IDLE.
  - Otherwise -> READ.
- la_data and la_addr hold stable throughout PRESENT and after completion, until the next CAPTURE.
- Address wrap: start_addr=14 with count=4 on a 16-deep RAM reads 14, 15, 0, 1.
- Abort (synchronised high) in any non-IDLE state:
  - -> IDLE next cycle; busy and cpu_hold drop.
  - done stays 0, and la_valid_tgl does not toggle further.
  - Abort held high blocks starts.
- A start edge while busy is ignored; an edge that occurs during busy is not queued.
- An ack toggle seen outside PRESENT is absorbed into the reference: the reference is resynced on entering HOLD, so stale acks never skip a word.
- Simultaneous abort and ack in PRESENT: abort wins.
- Asynchronous reset mid-dump: everything returns to reset values immediately; ram_rd_en drops combinationally with the state.
- Per-word latency: la_valid_tgl flips 2 cycles after entering READ, and the next READ follows 1 cycle after the ack is detected.

Test Plan:
- RAM preloaded with mem[i]=0xA0+i; start_addr=0, count=3 → la_valid_tgl toggles 3 times with (addr, data) = (0,A0), (1,A1), (2,A2); done=1; busy=0; cpu_hold was high throughout.
- Wrap: start_addr=14, count=4 → addresses 14, 15, 0, 1 with data AE, AF, A0, A1.
- count=0 → 16 words at addresses 0..15; done set only after the 16th ack; exactly 16 ram_rd_en pulses.
- Abort after the 2nd word is presented → busy and cpu_hold fall within 3 cycles of la_abort rising; done=0; no further ram_rd_en; la_data holds A1.
- Backpressure: no ack for 50 cycles → la_data is stable and no ram_rd_en occurs; a start edge issued during busy is ignored and the word count is unchanged.
- Reset asserted during READ → all outputs 0 that same cycle; after release, a new start runs a clean dump from la_start_addr.
